ram_loader: RTL and testbench

- Bootstrap sequencer that fills the 16x8 program RAM from a byte stream before the CPU runs.
- Owns the RAM programming path while active: drives prog_mode, the address/data switch inputs, MAR load and write strobes.
- Optionally reads back each byte and checks it.
- Returns control to the run-mode bus by deasserting prog_mode when done.

---
 rtl/ram_loader.sv | 92 +++++++++
 tb/tb_ram_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: bootstrap sequencer that fills the program RAM from a byte stream before the CPU runs
//   clk, clear        : rising-edge clock, synchronous active-high reset (aborts a load at once)
//   start             : one-cycle pulse, begins a load when idle
//   in_data/in_valid  : byte stream source, consumed when in_ready is high
//   in_ready          : high only while waiting for the next byte
//   prog_mode, busy   : high for the whole load, drop in the finishing cycle
//   ram_addr/ram_data : address and data presented to the RAM switch inputs
//   load_addr         : MAR load strobe, write_enable : RAM write strobe
//   output_enable     : RAM read drive, held over the read and check cycles
//   ram_rdata         : RAM read-back data, sampled one cycle after output_enable rises
//   done              : one-cycle pulse on a load that verified cleanly
//   error, err_addr   : sticky mismatch flag and the address of the first mismatch
module ram_loader #(
    parameter int ADDR_W     = 4,
    parameter int START_ADDR = 0,
    parameter int VERIFY     = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              load_addr,
    output logic              write_enable,
    output logic              output_enable,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic VFY = VERIFY != 0;
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SET_ADDR, WRITE, READ, CHECK, FINISH} state_t;
    state_t state, state_n;
    logic last, advance;
    assign last = ram_addr == LAST;
    // the word is complete after CHECK, or straight after WRITE when read-back is disabled
    assign advance = state == CHECK || (state == WRITE && !VFY);
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? WAIT_BYTE : IDLE;
            WAIT_BYTE: state_n = in_valid ? SET_ADDR : WAIT_BYTE;
            SET_ADDR:  state_n = WRITE;
            WRITE:     state_n = VFY ? READ : (last ? FINISH : WAIT_BYTE);
            READ:      state_n = CHECK;
            CHECK:     state_n = last ? FINISH : WAIT_BYTE;
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_comb begin
        in_ready      = state == WAIT_BYTE;
        busy          = state != IDLE && state != FINISH;
        prog_mode     = state != IDLE && state != FINISH;
        load_addr     = state == SET_ADDR;
        write_enable  = state == WRITE;
        output_enable = state == READ || state == CHECK;
        done          = state == FINISH && !error;
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            ram_addr <= FIRST;
            ram_data <= '0;
            error    <= 1'b0;
            err_addr <= '0;
        end else begin
            if (state == IDLE && start) begin
                ram_addr <= FIRST;
                error    <= 1'b0;
                err_addr <= '0;
            end
            if (state == WAIT_BYTE && in_valid) ram_data <= in_data;
            if (state == CHECK && ram_rdata != ram_data && !error) begin
                error    <= 1'b1;
                err_addr <= ram_addr;
            end
            if (advance && !last) ram_addr <= ram_addr + 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader with a RAM model, default and START_ADDR=12/VERIFY=0 instances
module tb_ram_loader;
    logic clk = 0;
    logic clear = 1;
    logic mem_init = 1;
    logic corrupt = 0;
    logic [1:0] start = 0, in_valid = 0;
    logic [1:0] in_ready, prog_mode, load_addr, write_enable, output_enable, busy, done, error;
    logic [7:0] in_data [2];
    logic [7:0] ram_data [2];
    logic [7:0] rdata [2];
    logic [3:0] ram_addr [2];
    logic [3:0] err_addr [2];
    logic [3:0] mar [2];
    logic [7:0] mem [2][16];
    logic [12:0] sb [$];
    int total = 0, bad = 0;
    int cyc_la [2], cyc_we [2], cyc_oe [2], cyc_done [2];

    always #5 clk = ~clk;

    ram_loader u0 (
        .clk(clk), .clear(clear), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .prog_mode(prog_mode[0]), .ram_addr(ram_addr[0]), .ram_data(ram_data[0]),
        .load_addr(load_addr[0]), .write_enable(write_enable[0]), .output_enable(output_enable[0]),
        .ram_rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .error(error[0]), .err_addr(err_addr[0])
    );

    ram_loader #(.START_ADDR(12), .VERIFY(0)) u1 (
        .clk(clk), .clear(clear), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .prog_mode(prog_mode[1]), .ram_addr(ram_addr[1]), .ram_data(ram_data[1]),
        .load_addr(load_addr[1]), .write_enable(write_enable[1]), .output_enable(output_enable[1]),
        .ram_rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .error(error[1]), .err_addr(err_addr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: MAR latched on load_addr, write on write_enable, registered read with optional corruption
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mem_init) begin
                for (int a = 0; a < 16; a++) mem[u][a] <= 8'h00;
                mar[u] <= 4'h0;
                rdata[u] <= 8'h00;
            end else begin
                if (load_addr[u]) mar[u] <= ram_addr[u];
                if (write_enable[u]) mem[u][mar[u]] <= ram_data[u];
                if (output_enable[u])
                    rdata[u] <= (corrupt && mar[u] == 4'd3) ? 8'hFF :
                                (corrupt && mar[u] == 4'd9) ? ~mem[u][mar[u]] : mem[u][mar[u]];
            end
        end
    end

    // monitor: counts strobe cycles and checks every write against the scoreboard
    always @(negedge clk) begin
        logic [12:0] e;
        for (int u = 0; u < 2; u++) begin
            if (load_addr[u]) cyc_la[u]++;
            if (write_enable[u]) cyc_we[u]++;
            if (output_enable[u]) cyc_oe[u]++;
            if (done[u]) cyc_done[u]++;
            if (load_addr[u] | write_enable[u] | output_enable[u])
                chk("strobe_excl", 32'(load_addr[u]) + 32'(write_enable[u]) + 32'(output_enable[u]), 1);
            if (in_ready[u])
                chk("ready_wait_only", {load_addr[u], write_enable[u], output_enable[u], busy[u]}, 4'b0001);
            if (write_enable[u]) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_write: got addr %0h data %0h expected none", mar[u], ram_data[u]);
                end else begin
                    e = sb.pop_front();
                    chk("sb_write", {1'(u), mar[u], ram_data[u]}, 32'(e));
                    chk("sb_addr", 32'(ram_addr[u]), 32'(e[11:8]));
                end
            end
        end
    end

    task automatic clr_counts();
        for (int u = 0; u < 2; u++) begin
            cyc_la[u] = 0;
            cyc_we[u] = 0;
            cyc_oe[u] = 0;
            cyc_done[u] = 0;
        end
    endtask

    task automatic pulse_start(input int u);
        @(posedge clk);
        #1 start[u] = 1;
        @(posedge clk);
        #1 start[u] = 0;
    endtask

    task automatic send_byte(input int u, input logic [3:0] a, input logic [7:0] d,
                             input int gap, input bit hold, input bit wiggle);
        int n = 0;
        sb.push_back({1'(u), a, d});
        while (in_ready[u] !== 1'b1 && n < 100) begin
            if (wiggle) begin
                in_valid[u] = 1'($urandom_range(0, 1));
                in_data[u] = 8'hEE;
            end
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(in_ready[u]), 1);
        if (!hold) in_valid[u] = 0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            chk("gap_idle", {load_addr[u], write_enable[u], output_enable[u], in_ready[u]}, 4'b0001);
        end
        in_data[u] = d;
        in_valid[u] = 1;
        @(posedge clk);
        #1 if (!hold) in_valid[u] = 0;
    endtask

    task automatic wait_idle(input int u);
        int n = 0;
        while (busy[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("finish_timeout", 32'(busy[u]), 0);
        repeat (3) @(negedge clk);
        in_valid[u] = 0;
    endtask

    initial begin
        int act;
        in_data[0] = 0;
        in_data[1] = 0;
        clr_counts();
        repeat (2) @(posedge clk);
        #1 clear = 0;
        mem_init = 0;
        chk("rst_strobes0", {load_addr[0], write_enable[0], output_enable[0], in_ready[0], done[0]}, 0);
        chk("rst_mode0", {prog_mode[0], busy[0], error[0]}, 0);
        chk("rst_addr0", {ram_addr[0], err_addr[0], ram_data[0]}, 0);
        chk("rst_addr1", 32'(ram_addr[1]), 12);
        chk("rst_mode1", {prog_mode[1], busy[1], write_enable[1]}, 0);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if ((load_addr | write_enable | output_enable | prog_mode | busy | in_ready | done) != 0) act++;
        end
        chk("idle_quiet", act, 0);

        clr_counts();
        pulse_start(0);
        chk("start_busy", {busy[0], prog_mode[0]}, 2'b11);
        for (int i = 0; i < 16; i++) send_byte(0, 4'(i), 8'h10 + 8'(i), 0, 1, 0);
        wait_idle(0);
        chk("full_la", cyc_la[0], 16);
        chk("full_we", cyc_we[0], 16);
        chk("full_oe", cyc_oe[0], 32);
        chk("full_done", cyc_done[0], 1);
        chk("full_mode", {prog_mode[0], error[0]}, 0);
        chk("full_sb_empty", sb.size(), 0);
        for (int i = 0; i < 16; i++) chk("full_mem", mem[0][i], 8'h10 + 8'(i));

        clr_counts();
        pulse_start(0);
        for (int i = 0; i < 16; i++) send_byte(0, 4'(i), 8'h20 + 8'(i), i == 5 ? 7 : $urandom_range(0, 2), 0, 1);
        wait_idle(0);
        chk("bp_done", cyc_done[0], 1);
        chk("bp_we", cyc_we[0], 16);
        chk("bp_sb_empty", sb.size(), 0);
        for (int i = 0; i < 16; i++) chk("bp_mem", mem[0][i], 8'h20 + 8'(i));

        clr_counts();
        corrupt = 1;
        pulse_start(0);
        for (int i = 0; i < 16; i++) send_byte(0, 4'(i), 8'h30 + 8'(i), 0, 0, 0);
        wait_idle(0);
        chk("verr_error", 32'(error[0]), 1);
        chk("verr_addr", 32'(err_addr[0]), 3);
        chk("verr_no_done", cyc_done[0], 0);
        chk("verr_idle", {busy[0], prog_mode[0]}, 0);
        corrupt = 0;
        clr_counts();
        pulse_start(0);
        chk("restart_clears", {error[0], err_addr[0], busy[0]}, 6'b000001);
        for (int i = 0; i < 16; i++) send_byte(0, 4'(i), 8'h40 + 8'(i), 0, 0, 0);
        wait_idle(0);
        chk("restart_done", {cyc_done[0][7:0], 7'(0), error[0]}, {8'd1, 8'd0});

        clr_counts();
        pulse_start(0);
        for (int i = 0; i < 7; i++) send_byte(0, 4'(i), 8'h60 + 8'(i), 0, 0, 0);
        act = 0;
        while (!write_enable[0] && act < 20) begin
            @(negedge clk);
            act++;
        end
        clear = 1;
        @(posedge clk);
        #1 clear = 0;
        chk("abort_we", {write_enable[0], load_addr[0], output_enable[0], in_ready[0]}, 0);
        chk("abort_mode", {prog_mode[0], busy[0]}, 0);
        chk("abort_addr", 32'(ram_addr[0]), 0);
        chk("abort_mem6", mem[0][6], 8'h66);
        act = 0;
        repeat (5) begin
            @(negedge clk);
            if ((load_addr[0] | write_enable[0] | output_enable[0] | busy[0]) != 0) act++;
        end
        chk("abort_quiet", act, 0);
        chk("abort_no_done", cyc_done[0], 0);
        clr_counts();
        pulse_start(0);
        for (int i = 0; i < 16; i++) send_byte(0, 4'(i), 8'h50 + 8'(i), 0, 0, 0);
        wait_idle(0);
        chk("reload_done", cyc_done[0], 1);
        chk("reload_mem0", mem[0][0], 8'h50);
        chk("reload_mem15", mem[0][15], 8'h5F);

        clr_counts();
        pulse_start(1);
        send_byte(1, 4'd12, 8'hA0, 0, 0, 0);
        pulse_start(1);
        for (int i = 1; i < 4; i++) begin
            send_byte(1, 4'(12 + i), 8'hA0 + 8'(i), 0, 0, 0);
            if (i == 2) pulse_start(1);
        end
        wait_idle(1);
        chk("s12_we", cyc_we[1], 4);
        chk("s12_la", cyc_la[1], 4);
        chk("s12_no_oe", cyc_oe[1], 0);
        chk("s12_done", cyc_done[1], 1);
        chk("s12_mode", {prog_mode[1], busy[1]}, 0);
        chk("s12_sb_empty", sb.size(), 0);
        for (int i = 0; i < 4; i++) chk("s12_mem", mem[1][12 + i], 8'hA0 + 8'(i));
        chk("s12_mem11", mem[1][11], 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
